// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS BCD countdown timer.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam int SU_LSB = 0;
    localparam int ST_LSB = 4;
    localparam int MU_LSB = 8;
    localparam int MT_LSB = 12;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    function automatic logic [3:0] sat_digit(
        input logic [3:0] d,
        input logic [3:0] mx
    );
        return (d > mx) ? mx : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> Max and flags a borrow to the next digit.
module bcd_down_digit (
    output logic [3:0] Q,
    output logic       Borrow,
    input  logic       CR,
    input  logic       En,
    input  logic       Load,
    input  logic [3:0] D,
    input  logic [3:0] Max,
    input  logic       CP
);

    logic [3:0] q_q;

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            q_q <= 4'd0;
        end else if (Load) begin
            q_q <= D;
        end else if (En) begin
            q_q <= (q_q == 4'd0) ? Max : q_q - 4'd1;
        end
    end

    assign Q      = q_q;
    assign Borrow = (q_q == 4'd0) & En;

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM:SS BCD countdown timer: control FSM, preset saturation and alarm logic
// around a four-digit borrow chain.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int MIN_TENS_MAX = 9,
    parameter int SEC_TENS_MAX = 5
) (
    input  logic        CP,
    input  logic        CR,
    input  logic        En,
    input  logic        Load,
    input  logic        Start,
    input  logic        Stop,
    input  logic [15:0] Preset,
    output logic [15:0] Cnt,
    output logic        Busy,
    output logic        Done,
    output logic        Alarm
);

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);
    localparam logic [3:0] ST_MAX = 4'(SEC_TENS_MAX);

    state_e     state_q, state_d;
    logic       busy_q, done_q, done_d, alarm_q, alarm_d;
    logic [3:0] dig [4];
    logic [3:0] bor;
    logic       tick, fire, cnt_zero, cnt_one;
    logic       unused_top_borrow;

    assign cnt_zero = (Cnt == 16'h0000);
    assign cnt_one  = (Cnt == 16'h0001);

    // Higher-priority controls on the same edge swallow the tick.
    assign tick = En & ~Load & ~Stop & ~Start
                & (state_q == RUN) & ~cnt_zero;
    assign fire = tick & cnt_one;

    for (genvar i = 0; i < 4; i++) begin : g_dig
        localparam logic [3:0] LIM = (i == 3) ? MT_MAX :
                                     (i == 1) ? ST_MAX : DIGIT_MAX;
        logic en_w;
        assign en_w = (i == 0) ? tick : bor[(i > 0) ? i - 1 : 0];
        bcd_down_digit u_dig (
            .Q      (dig[i]),
            .Borrow (bor[i]),
            .CR     (CR),
            .En     (en_w),
            .Load   (Load),
            .D      (sat_digit(Preset[i*4 +: 4], LIM)),
            .Max    (LIM),
            .CP     (CP)
        );
    end

    assign unused_top_borrow = bor[3];

    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        done_d  = 1'b0;
        if (Load) begin
            state_d = IDLE;
            alarm_d = 1'b0;
        end else if (Stop) begin
            if (state_q == RUN) state_d = PAUSE;
        end else if (Start) begin
            case (state_q)
                IDLE, PAUSE: state_d = cnt_zero ? IDLE : RUN;
                DONE: begin
                    state_d = IDLE;
                    alarm_d = 1'b0;
                end
                default: state_d = state_q;
            endcase
        end else if (fire) begin
            state_d = DONE;
            done_d  = 1'b1;
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= done_d;
            alarm_q <= alarm_d;
        end
    end

    assign Cnt   = {dig[3], dig[2], dig[1], dig[0]};
    assign Busy  = busy_q;
    assign Done  = done_q;
    assign Alarm = alarm_q;

endmodule
